// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Multiplies use
//   shift-add over a 2*XLEN accumulator. Divides use restoring division.
//   Both retire BITS_PER_CYCLE bits per clock. Divide-by-zero and signed
//   overflow are resolved at accept and finish after one cycle.
//
// Parameters
//   XLEN            operand/result width
//   BITS_PER_CYCLE  bits retired per iteration (1, 2 or 4; must divide XLEN)
//   TAG_W           passthrough tag width
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   flush      synchronous abort of in-flight or unconsumed op
//   in_valid   op/operands valid          in_ready   unit idle, can accept
//   funct3     M-extension op select      rs1/rs2    operands
//   in_tag     tag captured on accept
//   out_valid  result valid               out_ready  consumer takes result
//   result     final result               out_tag    tag of the result
//   busy       unit not idle
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  // Multiply: low half holds the multiplier shifting out, high half the
  // partial product. Divide: low half holds dividend/quotient, high half
  // the partial remainder.
  logic [2*XLEN-1:0]   acc_reg;
  // Multiplicand for MUL, divisor for DIV.
  logic [XLEN-1:0]     opb_reg;
  logic [1:0]          op_reg;
  logic                neg_res_reg;
  logic                neg_rem_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [XLEN-1:0]     result_reg;
  logic [TAG_W-1:0]    out_tag_reg;

  // ---------------- accept-side decode ----------------
  logic            accept;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_overflow, special;
  logic [XLEN-1:0] special_res;

  assign accept = in_valid & (state_reg == ST_IDLE) & ~flush;

  // Divides: signed when funct3[0] = 0. Multiplies: rs1 signed except
  // MULHU, rs2 signed only for MUL/MULH.
  assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign a_neg    = a_signed & rs1[XLEN-1];
  assign b_neg    = b_signed & rs2[XLEN-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;

  assign div_by_zero  = (rs2 == '0);
  assign div_overflow = ~funct3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
  assign special      = funct3[2] & (div_by_zero | div_overflow);
  // funct3[1] selects the remainder flavour of the divide.
  assign special_res  = div_by_zero ? (funct3[1] ? rs1 : '1)
                                    : (funct3[1] ? '0  : rs1);

  // ---------------- iteration datapath ----------------
  logic [2*XLEN-1:0] stage_mul [0:BITS_PER_CYCLE];
  logic [XLEN-1:0]   stage_rem [0:BITS_PER_CYCLE];
  logic [XLEN-1:0]   stage_quo [0:BITS_PER_CYCLE];

  assign stage_mul[0] = acc_reg;
  assign stage_rem[0] = acc_reg[2*XLEN-1:XLEN];
  assign stage_quo[0] = acc_reg[XLEN-1:0];

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [XLEN:0] sum;
      logic [XLEN:0] shifted;
      logic          ge;

      // Shift-add: add multiplicand into the high half when the current
      // multiplier bit is set, then shift the whole accumulator right.
      // The carry out of the add becomes the new top bit.
      assign sum = {1'b0, stage_mul[gi][2*XLEN-1:XLEN]} + {1'b0, opb_reg};
      assign stage_mul[gi+1] = stage_mul[gi][0]
                             ? {sum, stage_mul[gi][XLEN-1:1]}
                             : {1'b0, stage_mul[gi][2*XLEN-1:1]};

      // Restoring step: bring in the next dividend bit, subtract the
      // divisor when it fits, record the quotient bit.
      assign shifted = {stage_rem[gi], stage_quo[gi][XLEN-1]};
      assign ge      = (shifted >= {1'b0, opb_reg});
      assign stage_rem[gi+1] = ge ? XLEN'(shifted - {1'b0, opb_reg})
                                  : shifted[XLEN-1:0];
      assign stage_quo[gi+1] = {stage_quo[gi][XLEN-2:0], ge};
    end
  endgenerate

  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   mul_res, div_res;

  assign acc_step = (state_reg == ST_MUL) ? stage_mul[BITS_PER_CYCLE]
                                          : {stage_rem[BITS_PER_CYCLE], stage_quo[BITS_PER_CYCLE]};

  // Final sign fix-ups, taken from the last iteration's combinational
  // output so the result register loads on the same edge that enters DONE.
  assign prod_fix = neg_res_reg ? -stage_mul[BITS_PER_CYCLE] : stage_mul[BITS_PER_CYCLE];
  assign quo_fix  = neg_res_reg ? -stage_quo[BITS_PER_CYCLE] : stage_quo[BITS_PER_CYCLE];
  assign rem_fix  = neg_rem_reg ? -stage_rem[BITS_PER_CYCLE] : stage_rem[BITS_PER_CYCLE];
  assign mul_res  = (op_reg == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign div_res  = op_reg[1] ? rem_fix : quo_fix;

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!funct3[2])   state_next = ST_MUL;
          else if (special) state_next = ST_DONE;
          else              state_next = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_reg == LAST_CNT) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Flush overrides every transition, including the result handshake.
    if (flush) state_next = ST_IDLE;
  end

  logic             load_result;
  logic [XLEN-1:0]  result_next;
  logic [TAG_W-1:0] out_tag_next;

  always_comb begin
    load_result  = (state_next == ST_DONE) && (state_reg != ST_DONE);
    result_next  = div_res;
    out_tag_next = tag_reg;
    if (state_reg == ST_IDLE) begin
      result_next  = special_res;
      out_tag_next = in_tag;
    end else if (state_reg == ST_MUL) begin
      result_next  = mul_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opb_reg     <= '0;
      op_reg      <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      tag_reg     <= '0;
      result_reg  <= '0;
      out_tag_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg     <= '0;
        op_reg      <= funct3[1:0];
        neg_res_reg <= a_neg ^ b_neg;
        neg_rem_reg <= a_neg;
        tag_reg     <= in_tag;
        if (funct3[2]) begin
          acc_reg <= {{XLEN{1'b0}}, a_mag};
          opb_reg <= b_mag;
        end else begin
          acc_reg <= {{XLEN{1'b0}}, b_mag};
          opb_reg <= a_mag;
        end
      end else if (state_reg == ST_MUL || state_reg == ST_DIV) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        acc_reg <= acc_step;
      end
      if (load_result) begin
        result_reg  <= result_next;
        out_tag_reg <= out_tag_next;
      end
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: a vector table, random ops against
// a reference model, and hand-written flush / hold / reset sequences. A
// second instance with BITS_PER_CYCLE = 4 checks the shorter latency.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [4:0]  out_tag;

  logic        in_valid4 = 1'b0;
  logic        out_ready4 = 1'b0;
  logic [2:0]  funct3_4 = '0;
  logic [31:0] rs1_4 = '0, rs2_4 = '0;
  logic [4:0]  in_tag4 = '0;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] result4;
  logic [4:0]  out_tag4;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .busy(busy));

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_dut4 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid4), .in_ready(in_ready4),
    .funct3(funct3_4), .rs1(rs1_4), .rs2(rs2_4), .in_tag(in_tag4), .out_valid(out_valid4),
    .out_ready(out_ready4), .result(result4), .out_tag(out_tag4), .busy(busy4));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] as32, bs32, qs;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as32 = a;
    bs32 = b;
    ref_fn = '0;
    case (f3)
      3'd0: begin p = sa * sb; ref_fn = p[31:0];  end
      3'd1: begin p = sa * sb; ref_fn = p[63:32]; end
      3'd2: begin p = sa * ub; ref_fn = p[63:32]; end
      3'd3: begin p = ua * ub; ref_fn = p[63:32]; end
      3'd4: begin
        if (b == 0) ref_fn = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_fn = a;
        else begin qs = as32 / bs32; ref_fn = qs; end
      end
      3'd5: ref_fn = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_fn = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_fn = '0;
        else begin qs = as32 % bs32; ref_fn = qs; end
      end
      default: ref_fn = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one op on the BITS_PER_CYCLE = 1 instance, measures latency,
  // pops the scoreboard on out_valid, optionally holds out_ready low.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_res, input int exp_lat,
                        input int hold);
    int   lat;
    exp_t e;
    logic [31:0] held;
    check("in_ready_before_op", in_ready, 1);
    funct3 = f3; rs1 = a; rs2 = b; in_tag = tag; in_valid = 1'b1;
    sb_q.push_back('{res: exp_res, tag: tag});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    e = sb_q.pop_front();
    if (out_valid) begin
      check("result", result, e.res);
      check("out_tag", out_tag, e.tag);
      held = result;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_result", result, held);
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("in_ready_after_handshake", in_ready, 1);
      check("out_valid_after_handshake", out_valid, 0);
    end
  endtask

  initial begin
    int          seen;
    int          lat;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          exp_lat;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'h7FFF_FFFC, 33};
    vecs[7]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF, 1};
    vecs[8]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 5'd9,  32'h0000_0005, 1};
    vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1};
    vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1};
    vecs[11] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 5'd12, 32'h0000_0002, 33};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd13, 32'hFFFF_FFF9, 1};
    vecs[13] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 5'd31, 32'h0000_0001, 33};

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat, 0);

    // Random ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
      run_op(f3, a, b, 5'(i), ref_fn(f3, a, b), exp_lat, 0);
    end

    // Backpressure: result held for 5 cycles.
    run_op(3'd0, 32'd6, 32'd7, 5'd17, 32'd42, 33, 5);

    // Flush 10 cycles into a DIV.
    funct3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; in_tag = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("div_started_busy", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", seen, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd14, 32'd12, 33, 0);

    // Flush coincident with in_valid in IDLE: not accepted.
    funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd0; in_tag = 5'd21; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_busy", busy, 0);
    check("flush_accept_out_valid", out_valid, 0);
    check("flush_accept_result_kept", result, 32'd12);
    check("flush_accept_tag_kept", out_tag, 5'd14);

    // Reset pulse in the middle of a MUL.
    funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd5; in_tag = 5'd22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_out_tag", out_tag, 0);
    #2;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd23, 32'h0000_0001, 33, 0);

    // BITS_PER_CYCLE = 4 instance: MUL then DIV, both 9 cycles.
    for (int k = 0; k < 2; k++) begin
      check("bpc4_in_ready", in_ready4, 1);
      funct3_4 = (k == 0) ? 3'd0 : 3'd4;
      rs1_4    = (k == 0) ? 32'd7 : 32'hFFFF_FFF9;
      rs2_4    = (k == 0) ? 32'hFFFF_FFFD : 32'd2;
      in_tag4  = 5'd5;
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      lat = 1;
      while (!out_valid4 && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      check("bpc4_latency", lat, 9);
      check("bpc4_result", result4, (k == 0) ? 32'hFFFF_FFEB : 32'hFFFF_FFFD);
      check("bpc4_out_tag", out_tag4, 5'd5);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
    end

    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit for the EX stage, generalised over data width and bits retired per cycle. It sits beside the single-cycle ALU/CMP path. The EX stage routes M-extension ops (opcode op_reg, funct7 = 0000001) here and stalls ID/EX while the unit is busy. A valid/ready handshake is used on both the operand side and the result side, and a flush aborts in-flight work on a branch or jalr redirect.

## Interface
Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration. Legal values are 1, 2 and 4. XLEN % BITS_PER_CYCLE must equal 0.
- TAG_W, 5, width of the passthrough tag (rd index).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight or completed-but-unconsumed op.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept an op.
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  in  XLEN  operand a (dividend / multiplicand).
- rs2  in  XLEN  operand b (divisor / multiplier).
- in_tag  in  TAG_W  tag, captured on accept.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  final result.
- out_tag  out  TAG_W  tag captured on accept.
- busy  out  1  state ≠ IDLE.

## Operation
- Iteration count: ITER = XLEN / BITS_PER_CYCLE.
- States and transitions:
  - IDLE -> MUL on accept with funct3[2] = 0.
  - IDLE -> DIV on accept with funct3[2] = 1 and no special case.
  - IDLE -> DONE on accept of a divide special case.
  - MUL/DIV -> DONE after the last iteration.
  - DONE -> IDLE when out_ready = 1.
- Accept: an op is accepted when in_valid & in_ready & !flush. in_ready = (state == IDLE).
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Operand and sign capture: on accept, magnitudes are captured and result sign flags are recorded.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- MUL datapath: shift-add over a 2·XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle. On completion the product is negated if the sign flag is set.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- DIV datapath: restoring division, BITS_PER_CYCLE quotient bits per cycle. On completion the quotient and remainder are sign-fixed separately.
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
- Special cases (resolved at accept, latency 1):
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones, DIV/REM only): quotient = rs1; remainder = 0.
- result and out_tag are registered and change only on the edge that enters DONE.
- Flush: on any edge with flush = 1, state goes to IDLE and out_valid drops. Iteration registers need not be cleared. Flush wins over a simultaneous accept and over a simultaneous out_ready handshake; the result is discarded.
- Reset values (asynchronous, while rst = 0):
  - state = IDLE, so in_ready = 1, busy = 0, out_valid = 0.
  - result = 0, out_tag = 0, iteration counter = 0.
- Reset asserted mid-operation forces these values immediately. No partial result is ever presented.

## Timing
- The accept edge is E0.
- Normal MUL/DIV:
  - Iterations occupy edges E0+1 through E0+ITER.
  - out_valid = 1 in the cycle after edge E0+ITER.
  - Total latency is ITER+1 cycles; ITER = 32 gives 33 cycles.
- Special case: out_valid = 1 in the cycle after E0 (latency 1).
- While out_valid = 1 and out_ready = 0: result, out_tag and out_valid are held stable.
- Handshake edge: the edge with out_valid & out_ready & !flush returns the unit to IDLE. in_ready = 1 in the following cycle, so there is no back-to-back accept in the DONE cycle.
- Maximum throughput is one op per ITER+2 cycles.
- busy and in_ready are combinational from state only, never from in_valid, so the stall logic has no combinational loop.

## Test plan
- MUL rs1 = 7, rs2 = 0xFFFFFFFD, tag 5 -> result 0xFFFFFFEB, out_tag 5, out_valid exactly 33 cycles after accept (XLEN = 32, BITS_PER_CYCLE = 1). Repeat with BITS_PER_CYCLE = 4 -> 9 cycles.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed division of −7 by 2:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU same operands -> 0x7FFFFFFC.
- Special cases, each with out_valid one cycle after accept:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same -> 0.
- Flush and backpressure:
  - Flush 10 cycles into a DIV -> in_ready = 1 next cycle, no out_valid. A new MUL 3 × 4 then returns 12.
  - Flush coincident with in_valid in IDLE -> not accepted.
- Hold and reset:
  - out_ready held low for 5 cycles -> result stable, in_ready = 0 throughout.
  - rst pulsed low mid-MUL -> out_valid = 0 and in_ready = 1 immediately, result = 0.
